debug_panel: RTL and testbench

//  Parametrised board-level debug front end: debounces push-keys, assembles a

---
 rtl/debug_panel_if.sv | 54 +++++
 rtl/debug_panel.sv | 181 ++++++++++++++++++
 tb/tb_debug_panel.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_panel_if.sv
// debug_panel_if: bundles the board-side controls, the flattened debug bus
// and the display-side results of debug_panel into one port.
//   master : board / top level (drives keys, switches, debug bus; reads results)
//   slave  : debug_panel itself
// Signals:
//   sw_chunk, chunk_sel, load_key  operand entry (raw key, async)
//   step_key                       manual index step (raw key, async)
//   special, view_sel, lock_in     config mode and values captured in it
//   scroll_en                      timed auto-scroll enable (run mode)
//   words                          debug bus, word i = [i*WORD_W +: WORD_W]
//   switch_word, switch_nz         assembled operand and its non-zero flag
//   view_index, view_word          displayed index and its registered word
//   clock_lock                     latched lock flag
//   load_pulse, step_pulse         one-cycle debounced press pulses
interface debug_panel_if #(
  parameter int WORD_W    = 16,
  parameter int SW_W      = 8,
  parameter int NUM_WORDS = 32
);
  localparam int N_CHUNKS = WORD_W / SW_W;
  localparam int CH_W     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int IX_W     = $clog2(NUM_WORDS);

  logic [SW_W-1:0]             sw_chunk;
  logic [CH_W-1:0]             chunk_sel;
  logic                        load_key;
  logic                        step_key;
  logic                        special;
  logic [IX_W-1:0]             view_sel;
  logic                        lock_in;
  logic                        scroll_en;
  logic [NUM_WORDS*WORD_W-1:0] words;
  logic [WORD_W-1:0]           switch_word;
  logic                        switch_nz;
  logic [IX_W-1:0]             view_index;
  logic [WORD_W-1:0]           view_word;
  logic                        clock_lock;
  logic                        load_pulse;
  logic                        step_pulse;

  modport master (
    output sw_chunk, chunk_sel, load_key, step_key, special, view_sel,
           lock_in, scroll_en, words,
    input  switch_word, switch_nz, view_index, view_word, clock_lock,
           load_pulse, step_pulse
  );

  modport slave (
    input  sw_chunk, chunk_sel, load_key, step_key, special, view_sel,
           lock_in, scroll_en, words,
    output switch_word, switch_nz, view_index, view_word, clock_lock,
           load_pulse, step_pulse
  );
endinterface

// File: rtl/debug_panel.sv
// debug_panel: board-level debug front end. Debounces the load and step keys
// into one-cycle pulses, assembles a WORD_W operand from SW_W switch chunks,
// and selects one word of the flattened debug bus for display, either by
// config-mode capture, manual stepping or timed auto-scroll.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high; clears every register
//   bus    debug_panel_if.slave (see the interface file for the signal list)
// All outputs on bus are registered.
module debug_panel #(
  parameter int WORD_W          = 16,
  parameter int SW_W            = 8,
  parameter int NUM_WORDS       = 32,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCROLL_CYCLES   = 25000000
) (
  input  logic         clock,
  input  logic         reset,
  debug_panel_if.slave bus
);
  localparam int N_CHUNKS = WORD_W / SW_W;
  localparam int CH_W     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int IX_W     = $clog2(NUM_WORDS);
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W     = $clog2(SCROLL_CYCLES + 1);
  localparam int KEYS     = 2;
  localparam int K_LOAD   = 0;
  localparam int K_STEP   = 1;

  logic [KEYS-1:0]   key_raw_s;
  logic [KEYS-1:0]   meta_r;
  logic [KEYS-1:0]   sync_r;
  logic [1:0]        vld_r;
  logic [KEYS-1:0]   deb_r;
  logic [KEYS-1:0]   deb_nxt_s;
  logic [KEYS-1:0]   rise_s;
  logic [KEYS-1:0]   armed_r;
  logic [KEYS-1:0]   pulse_r;
  logic [DB_W-1:0]   deb_cnt_r     [KEYS];
  logic [DB_W-1:0]   deb_cnt_nxt_s [KEYS];

  logic [SC_W-1:0]   scroll_r;
  logic [SC_W-1:0]   scroll_nxt_s;
  logic              tick_s;

  logic [WORD_W-1:0] word_r;
  logic [WORD_W-1:0] word_nxt_s;
  logic              nz_r;
  logic [IX_W-1:0]   idx_r;
  logic [IX_W-1:0]   idx_nxt_s;
  logic              lock_r;
  logic              lock_nxt_s;
  logic [WORD_W-1:0] vword_r;
  logic [WORD_W-1:0] word_arr_s [NUM_WORDS];

  assign key_raw_s = {bus.step_key, bus.load_key};

  // Unpack the flat debug bus into addressable words
  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      word_arr_s[i] = bus.words[i*WORD_W +: WORD_W];
    end
  end

  // Debounce: the accepted level flips only after DEBOUNCE_CYCLES consecutive
  // synchronised samples that differ from it; an agreeing sample restarts the count
  always_comb begin
    deb_nxt_s = deb_r;
    rise_s    = '0;
    for (int k = 0; k < KEYS; k++) begin
      deb_cnt_nxt_s[k] = '0;
      if (sync_r[k] != deb_r[k]) begin
        if (deb_cnt_r[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_nxt_s[k] = sync_r[k];
          rise_s[k]    = sync_r[k];
        end else begin
          deb_cnt_nxt_s[k] = deb_cnt_r[k] + DB_W'(1);
        end
      end else begin
        deb_cnt_nxt_s[k] = '0;
      end
    end
  end

  // Key synchronisers, debounce state and press pulses. A key is only armed
  // once a real post-reset sample shows it released, so a key held through
  // reset gives no pulse until it is let go and pressed again.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_r  <= '0;
      sync_r  <= '0;
      vld_r   <= '0;
      deb_r   <= '0;
      armed_r <= '0;
      pulse_r <= '0;
      for (int k = 0; k < KEYS; k++) begin
        deb_cnt_r[k] <= '0;
      end
    end else begin
      meta_r  <= key_raw_s;
      sync_r  <= meta_r;
      vld_r   <= {vld_r[0], 1'b1};
      deb_r   <= deb_nxt_s;
      armed_r <= armed_r | ({KEYS{vld_r[1]}} & ~sync_r);
      pulse_r <= rise_s & armed_r;
      for (int k = 0; k < KEYS; k++) begin
        deb_cnt_r[k] <= deb_cnt_nxt_s[k];
      end
    end
  end

  // Auto-scroll counter: runs only in run mode with scroll enabled, ticks on terminal count
  always_comb begin
    scroll_nxt_s = '0;
    tick_s       = 1'b0;
    if (bus.special || !bus.scroll_en) begin
      scroll_nxt_s = '0;
    end else if (scroll_r == SC_W'(SCROLL_CYCLES - 1)) begin
      tick_s       = 1'b1;
      scroll_nxt_s = '0;
    end else begin
      scroll_nxt_s = scroll_r + SC_W'(1);
    end
  end

  // Operand assembly: a load in run mode replaces only the selected chunk;
  // a chunk_sel past the last chunk matches nothing and leaves the word alone
  always_comb begin
    word_nxt_s = word_r;
    if (!bus.special && pulse_r[K_LOAD]) begin
      for (int c = 0; c < N_CHUNKS; c++) begin
        word_nxt_s[c*SW_W +: SW_W] = (bus.chunk_sel == CH_W'(c)) ?
                                     bus.sw_chunk : word_r[c*SW_W +: SW_W];
      end
    end else begin
      word_nxt_s = word_r;
    end
  end

  // View index and lock: captured in config mode, stepped by one in run mode
  // (a tick and a step pulse in the same cycle still advance by one)
  always_comb begin
    idx_nxt_s  = idx_r;
    lock_nxt_s = lock_r;
    if (bus.special) begin
      idx_nxt_s  = bus.view_sel;
      lock_nxt_s = bus.lock_in;
    end else if (tick_s || pulse_r[K_STEP]) begin
      idx_nxt_s = idx_r + IX_W'(1);
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Display and operand registers
  always_ff @(posedge clock) begin
    if (reset) begin
      word_r   <= '0;
      nz_r     <= 1'b0;
      idx_r    <= '0;
      lock_r   <= 1'b0;
      vword_r  <= '0;
      scroll_r <= '0;
    end else begin
      word_r   <= word_nxt_s;
      nz_r     <= |word_nxt_s;
      idx_r    <= idx_nxt_s;
      lock_r   <= lock_nxt_s;
      vword_r  <= word_arr_s[idx_r];
      scroll_r <= scroll_nxt_s;
    end
  end

  assign bus.switch_word = word_r;
  assign bus.switch_nz   = nz_r;
  assign bus.view_index  = idx_r;
  assign bus.view_word   = vword_r;
  assign bus.clock_lock  = lock_r;
  assign bus.load_pulse  = pulse_r[K_LOAD];
  assign bus.step_pulse  = pulse_r[K_STEP];
endmodule

// File: tb/tb_debug_panel.sv
// Bench for debug_panel. A behavioural model (raw key history, plain counters)
// runs beside the main instance and is compared every cycle; a second, small
// instance with three chunks per word exercises an out-of-range chunk_sel.
module tb_debug_panel;
  localparam int DEB = 4;
  localparam int SCR = 8;

  logic clock;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  debug_panel_if #(.WORD_W(16), .SW_W(8), .NUM_WORDS(32)) bus1 ();
  debug_panel_if #(.WORD_W(12), .SW_W(4), .NUM_WORDS(4))  bus2 ();

  debug_panel #(.WORD_W(16), .SW_W(8), .NUM_WORDS(32),
                .DEBOUNCE_CYCLES(DEB), .SCROLL_CYCLES(SCR))
    dut (.clock(clock), .reset(reset), .bus(bus1.slave));

  debug_panel #(.WORD_W(12), .SW_W(4), .NUM_WORDS(4),
                .DEBOUNCE_CYCLES(DEB), .SCROLL_CYCLES(SCR))
    dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

  assign bus2.load_key = bus1.load_key;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- behavioural model ----------------
  bit          hq_l[$];
  bit          hq_s[$];
  bit          m_deb_l, m_deb_s, m_lp, m_sp, m_nz, m_lock;
  logic [15:0] m_word, m_vw;
  int          m_idx, m_run;

  // Raw samples since reset reach the debounce logic two clocks late; the level
  // flips when the last DEB of those all disagree with it.
  function automatic bit deb_flip(input bit q[$], input bit deb);
    int k = q.size();
    if (k - 2 < DEB) return 1'b0;
    for (int j = k - 2 - DEB; j <= k - 3; j++) begin
      if (q[j] == deb) return 1'b0;
    end
    return 1'b1;
  endfunction

  // A press counts only if the key has been seen released since reset.
  function automatic bit seen_low(input bit q[$]);
    for (int j = 0; j <= q.size() - 3; j++) begin
      if (q[j] == 1'b0) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clock) begin : model
    int          nidx;
    logic [15:0] nword;
    logic [15:0] nvw;
    bit          nlock, tk, lr, sr;
    if (reset) begin
      hq_l.delete(); hq_s.delete();
      m_deb_l = 1'b0; m_deb_s = 1'b0; m_lp = 1'b0; m_sp = 1'b0;
      m_word = 16'h0; m_nz = 1'b0; m_idx = 0; m_lock = 1'b0; m_vw = 16'h0; m_run = 0;
    end else begin
      nvw   = bus1.words[m_idx*16 +: 16];
      nword = m_word;
      nidx  = m_idx;
      nlock = m_lock;
      if (bus1.special) begin
        nidx  = int'(bus1.view_sel);
        nlock = bus1.lock_in;
        m_run = 0;
      end else begin
        if (m_lp) begin
          if (bus1.chunk_sel == 1'b0) nword[7:0] = bus1.sw_chunk;
          else nword[15:8] = bus1.sw_chunk;
        end
        tk = 1'b0;
        if (bus1.scroll_en) begin
          m_run = m_run + 1;
          tk = (m_run % SCR) == 0;
        end else begin
          m_run = 0;
        end
        if (tk || m_sp) nidx = (m_idx + 1) % 32;
      end
      hq_l.push_back(bus1.load_key);
      hq_s.push_back(bus1.step_key);
      lr = 1'b0;
      sr = 1'b0;
      if (deb_flip(hq_l, m_deb_l)) begin
        m_deb_l = !m_deb_l;
        lr = m_deb_l && seen_low(hq_l);
      end
      if (deb_flip(hq_s, m_deb_s)) begin
        m_deb_s = !m_deb_s;
        sr = m_deb_s && seen_low(hq_s);
      end
      m_word = nword; m_nz = |nword; m_idx = nidx; m_lock = nlock;
      m_vw = nvw; m_lp = lr; m_sp = sr;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every output of the main instance to the model.
  task automatic tick();
    @(negedge clock);
    chk("switch_word", 64'(bus1.switch_word), 64'(m_word));
    chk("switch_nz",   64'(bus1.switch_nz),   64'(m_nz));
    chk("view_index",  64'(bus1.view_index),  64'(m_idx));
    chk("view_word",   64'(bus1.view_word),   64'(m_vw));
    chk("clock_lock",  64'(bus1.clock_lock),  64'(m_lock));
    chk("load_pulse",  64'(bus1.load_pulse),  64'(m_lp));
    chk("step_pulse",  64'(bus1.step_pulse),  64'(m_sp));
  endtask

  task automatic press(input bit which);
    if (which) bus1.step_key = 1'b1;
    else bus1.load_key = 1'b1;
    repeat (8) tick();
    bus1.step_key = 1'b0;
    bus1.load_key = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    bus1.sw_chunk = 8'h00; bus1.chunk_sel = 1'b0; bus1.load_key = 1'b0;
    bus1.step_key = 1'b0; bus1.special = 1'b0; bus1.view_sel = 5'd0;
    bus1.lock_in = 1'b0; bus1.scroll_en = 1'b0;
    for (int i = 0; i < 32; i++) bus1.words[i*16 +: 16] = 16'hC000 + 16'(i) * 16'h0101;
    bus2.sw_chunk = 4'h0; bus2.chunk_sel = 2'd3; bus2.step_key = 1'b0;
    bus2.special = 1'b0; bus2.view_sel = 2'd0; bus2.lock_in = 1'b0;
    bus2.scroll_en = 1'b0; bus2.words = 48'h0;
    repeat (3) tick();
    chk("rst_word", 64'(bus1.switch_word), 64'h0);
    chk("rst_index", 64'(bus1.view_index), 64'h0);
    reset = 1'b0;
    repeat (10) tick();

    // 1: bouncing load key gives one pulse, 6 clocks after the last edge
    cnt = 0;
    for (int b = 0; b < 2; b++) begin
      bus1.load_key = 1'b1;
      repeat (2) begin tick(); if (bus1.load_pulse) cnt++; end
      bus1.load_key = 1'b0;
      repeat (2) begin tick(); if (bus1.load_pulse) cnt++; end
    end
    bus1.load_key = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus1.load_pulse) cnt++;
      chk("t1_latency", 64'(bus1.load_pulse), 64'(i == 6));
    end
    chk("t1_one_pulse", 64'(cnt), 64'd1);
    bus1.load_key = 1'b0;
    cnt = 0;
    repeat (12) begin tick(); if (bus1.load_pulse) cnt++; end
    chk("t1_release", 64'(cnt), 64'd0);

    // 2: chunk entry, plus an out-of-range chunk on the three-chunk instance
    bus1.chunk_sel = 1'b1; bus1.sw_chunk = 8'hAB; bus2.chunk_sel = 2'd2; bus2.sw_chunk = 4'h5;
    press(1'b0);
    bus1.chunk_sel = 1'b0; bus1.sw_chunk = 8'hCD; bus2.chunk_sel = 2'd3; bus2.sw_chunk = 4'hF;
    press(1'b0);
    chk("t2_word", 64'(bus1.switch_word), 64'hABCD);
    chk("t2_nz", 64'(bus1.switch_nz), 64'd1);
    chk("t2_oob_chunk", 64'(bus2.switch_word), 64'h500);
    bus1.chunk_sel = 1'b1; bus1.sw_chunk = 8'hAB; bus2.chunk_sel = 2'd0; bus2.sw_chunk = 4'h7;
    press(1'b0);
    chk("t2_chunk0", 64'(bus2.switch_word), 64'h507);
    chk("t2_nz2", 64'(bus2.switch_nz), 64'd1);

    // 3: config capture; loads ignored
    bus1.special = 1'b1; bus1.view_sel = 5'd5; bus1.lock_in = 1'b1;
    tick();
    chk("t3_index", 64'(bus1.view_index), 64'd5);
    chk("t3_lock", 64'(bus1.clock_lock), 64'd1);
    tick();
    chk("t3_vword", 64'(bus1.view_word), 64'hC505);
    bus1.chunk_sel = 1'b0; bus1.sw_chunk = 8'h11;
    press(1'b0);
    chk("t3_load_ignored", 64'(bus1.switch_word), 64'hABCD);

    // 4: auto-scroll wrap and coincident step
    bus1.view_sel = 5'd30;
    repeat (2) tick();
    chk("t4_vword30", 64'(bus1.view_word), 64'hDE1E);
    bus1.special = 1'b0; bus1.scroll_en = 1'b1; bus1.lock_in = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 7)  chk("t4_hold30", 64'(bus1.view_index), 64'd30);
      if (i == 8)  chk("t4_to31", 64'(bus1.view_index), 64'd31);
      if (i == 9)  chk("t4_vword31", 64'(bus1.view_word), 64'hDF1F);
      if (i == 16) chk("t4_wrap0", 64'(bus1.view_index), 64'd0);
      if (i == 17) bus1.step_key = 1'b1;
      if (i == 23) chk("t4_step_coinc", 64'(bus1.step_pulse), 64'd1);
      if (i == 24) chk("t4_plus_one", 64'(bus1.view_index), 64'd1);
    end
    bus1.scroll_en = 1'b0; bus1.step_key = 1'b0;
    repeat (10) tick();
    chk("t4_idle", 64'(bus1.view_index), 64'd1);
    chk("t4_lock_kept", 64'(bus1.clock_lock), 64'd1);
    press(1'b1);
    chk("t4_manual_step", 64'(bus1.view_index), 64'd2);

    // 5: reset with key held and scroll mid-count
    bus1.scroll_en = 1'b1; bus1.load_key = 1'b1; bus1.chunk_sel = 1'b1; bus1.sw_chunk = 8'h3C;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("t5_word", 64'(bus1.switch_word), 64'h0);
    chk("t5_nz", 64'(bus1.switch_nz), 64'h0);
    chk("t5_index", 64'(bus1.view_index), 64'h0);
    chk("t5_vword", 64'(bus1.view_word), 64'h0);
    chk("t5_lock", 64'(bus1.clock_lock), 64'h0);
    chk("t5_lp", 64'(bus1.load_pulse), 64'h0);
    reset = 1'b0;
    cnt = 0;
    repeat (12) begin tick(); if (bus1.load_pulse) cnt++; end
    chk("t5_held_no_pulse", 64'(cnt), 64'd0);
    bus1.load_key = 1'b0;
    repeat (8) tick();
    cnt = 0;
    bus1.load_key = 1'b1;
    repeat (8) begin tick(); if (bus1.load_pulse) cnt++; end
    bus1.load_key = 1'b0;
    repeat (8) begin tick(); if (bus1.load_pulse) cnt++; end
    chk("t5_repress", 64'(cnt), 64'd1);
    chk("t5_word_after", 64'(bus1.switch_word), 64'h3C00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
